// File: rtl/interp_job_sched_if.sv
// Host descriptor, engine and status signals of the interpolation job scheduler.
// master = host/engine side, slave = scheduler side.
interface interp_job_sched_if #(
    parameter int ID_W   = 4,
    parameter int PEND_W = 3
);
    logic              job_valid;
    logic              job_ready;
    logic [5:0]        job_h0;
    logic [5:0]        job_v0;
    logic [3:0]        job_sw;
    logic [3:0]        job_sh;
    logic [ID_W-1:0]   job_id;

    logic              eng_start;
    logic [5:0]        eng_h0;
    logic [5:0]        eng_v0;
    logic [3:0]        eng_sw;
    logic [3:0]        eng_sh;
    logic              eng_o_valid;

    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              done_valid;
    logic [ID_W-1:0]   done_id;
    logic [1:0]        done_err;

    modport master (
        output job_valid, job_h0, job_v0, job_sw, job_sh, job_id, eng_o_valid,
        input  job_ready, eng_start, eng_h0, eng_v0, eng_sw, eng_sh,
        input  busy, pending, done_valid, done_id, done_err
    );

    modport slave (
        input  job_valid, job_h0, job_v0, job_sw, job_sh, job_id, eng_o_valid,
        output job_ready, eng_start, eng_h0, eng_v0, eng_sw, eng_sh,
        output busy, pending, done_valid, done_id, done_err
    );
endinterface

// File: rtl/interp_job_sched.sv
// Job scheduler for the bilinear interpolation engine: descriptor FIFO, geometry check,
// START/beat-count sequencing. Optional watchdog enabled by INTERP_JOB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a queued descriptor; pops the FIFO head when present
// LAUNCH | one cycle; engine START is issued from this state
// RUN    | counting engine O_VALID beats
// DRAIN  | GAP_CYC quiet cycles after the last beat
// REPORT | one cycle; completion status is issued from this state
module interp_job_sched #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ID_W        = 4,
    parameter int OUT_PER_JOB = 289,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              RST,
    interp_job_sched_if.slave bus
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DESC_W = ID_W + 20;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("interp_job_sched: FIFO_DEPTH must be a power of two, at least 2");
    end
    if ((OUT_PER_JOB < 1) || (OUT_PER_JOB > 1023)) begin : g_bad_beats
        $error("interp_job_sched: OUT_PER_JOB must fit the 10-bit beat counter");
    end
    if ((GAP_CYC < 0) || (GAP_CYC > 255)) begin : g_bad_gap
        $error("interp_job_sched: GAP_CYC out of range");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("interp_job_sched: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DESC_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ready_q;
    logic              push;
    logic              pop;

    logic [DESC_W-1:0] head;
    logic [ID_W-1:0]   head_id;
    logic [5:0]        head_h0;
    logic [5:0]        head_v0;
    logic [3:0]        head_sw;
    logic [3:0]        head_sh;
    logic [6:0]        h_sum;
    logic [6:0]        v_sum;
    logic              head_ok;

    logic [5:0]        eng_h0_q;
    logic [5:0]        eng_v0_q;
    logic [3:0]        eng_sw_q;
    logic [3:0]        eng_sh_q;
    logic [ID_W-1:0]   cur_id;
    logic [1:0]        cur_err;

    logic [9:0]        beat_cnt;
    logic              beat_last;
    logic [7:0]        gap_cnt;
    logic              gap_last;

    logic              start_d;
    logic              done_d;
    logic              busy_d;
    logic              eng_start_q;
    logic              done_valid_q;
    logic              busy_q;
    logic [ID_W-1:0]   done_id_q;
    logic [1:0]        done_err_q;

    // job_ready is the registered !full, so a push while full can never happen
    assign push = bus.job_valid && ready_q;
    assign pop  = (state == S_IDLE) && (fifo_cnt != '0);

    assign head    = fifo_mem[rd_ptr];
    assign head_id = head[DESC_W-1:20];
    assign head_h0 = head[19:14];
    assign head_v0 = head[13:8];
    assign head_sw = head[7:4];
    assign head_sh = head[3:0];
    assign h_sum   = {1'b0, head_h0} + {3'b000, head_sw};
    assign v_sum   = {1'b0, head_v0} + {3'b000, head_sh};
    assign head_ok = (head_sw != 4'd0) && (head_sh != 4'd0) &&
                     (h_sum <= 7'd63) && (v_sum <= 7'd63);

    assign beat_last = (state == S_RUN) && bus.eng_o_valid &&
                       (beat_cnt == 10'(OUT_PER_JOB - 1));
    assign gap_last  = (gap_cnt == 8'(GAP_CYC - 1));

`ifdef INTERP_JOB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wdog;
    logic            timeout_hit;

    // a beat completing the job in the same cycle wins over the watchdog
    assign timeout_hit = (state == S_RUN) && !beat_last &&
                         (wdog == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wdog <= '0;
        end else if (state == S_LAUNCH) begin
            wdog <= '0;
        end else if (state == S_RUN) begin
            wdog <= wdog + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.job_id, bus.job_h0, bus.job_v0, bus.job_sw, bus.job_sh};
        end
    end

    always_comb begin
        cnt_nxt = fifo_cnt;
        if (push && !pop) begin
            cnt_nxt = fifo_cnt + 1'b1;
        end else if (pop && !push) begin
            cnt_nxt = fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ready_q  <= 1'b1;
            eng_h0_q <= '0;
            eng_v0_q <= '0;
            eng_sw_q <= '0;
            eng_sh_q <= '0;
            cur_id   <= '0;
            cur_err  <= 2'b00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                eng_h0_q <= head_h0;
                eng_v0_q <= head_v0;
                eng_sw_q <= head_sw;
                eng_sh_q <= head_sh;
                cur_id   <= head_id;
                cur_err  <= head_ok ? 2'b00 : 2'b01;
            end
`ifdef INTERP_JOB_TIMEOUT_EN
            if (timeout_hit) begin
                cur_err <= 2'b10;
            end
`endif
            fifo_cnt <= cnt_nxt;
            ready_q  <= (cnt_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    // beats outside RUN, or past the terminal count, never reach the counter
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            beat_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                S_LAUNCH: beat_cnt <= '0;
                S_RUN: begin
                    gap_cnt <= '0;
                    if (bus.eng_o_valid) begin
                        beat_cnt <= beat_cnt + 10'd1;
                    end
                end
                S_DRAIN:  gap_cnt <= gap_cnt + 8'd1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fifo_cnt != '0) begin
                    state_nxt = head_ok ? S_LAUNCH : S_REPORT;
                end
            end
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN: begin
                if (beat_last) begin
                    state_nxt = (GAP_CYC == 0) ? S_REPORT : S_DRAIN;
                end
`ifdef INTERP_JOB_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_nxt = S_REPORT;
                end
`endif
            end
            S_DRAIN: begin
                if (gap_last) begin
                    state_nxt = S_REPORT;
                end
            end
            S_REPORT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // START and the done pulse appear in the cycle after LAUNCH/REPORT; busy tracks state
    always_comb begin
        start_d = (state == S_LAUNCH);
        done_d  = (state == S_REPORT);
        busy_d  = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            eng_start_q  <= 1'b0;
            done_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_id_q    <= '0;
            done_err_q   <= 2'b00;
        end else begin
            eng_start_q  <= start_d;
            done_valid_q <= done_d;
            busy_q       <= busy_d;
            if (done_d) begin
                done_id_q  <= cur_id;
                done_err_q <= cur_err;
            end
        end
    end

    assign bus.job_ready  = ready_q;
    assign bus.eng_start  = eng_start_q;
    assign bus.eng_h0     = eng_h0_q;
    assign bus.eng_v0     = eng_v0_q;
    assign bus.eng_sw     = eng_sw_q;
    assign bus.eng_sh     = eng_sh_q;
    assign bus.busy       = busy_q;
    assign bus.pending    = fifo_cnt;
    assign bus.done_valid = done_valid_q;
    assign bus.done_id    = done_id_q;
    assign bus.done_err   = done_err_q;

endmodule

// File: tb/tb_interp_job_sched.sv
// Directed bench for interp_job_sched: scoreboard of launch descriptors and completion
// records filled at push time, checked whenever the DUT pulses eng_start or done_valid.
module tb_interp_job_sched;

    localparam int ID_W        = 4;
    localparam int PEND_W      = 3;
    localparam int OUT_PER_JOB = 289;
    localparam int TIMEOUT_CYC = 1024;

    logic clk = 1'b0;
    logic RST = 1'b1;

    always #5 clk = ~clk;

    interp_job_sched_if #(.ID_W(ID_W), .PEND_W(PEND_W)) sif ();

    interp_job_sched #(
        .FIFO_DEPTH (4),
        .ID_W       (ID_W),
        .OUT_PER_JOB(OUT_PER_JOB),
        .GAP_CYC    (2),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .RST(RST),
        .bus(sif)
    );

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int n_start   = 0;
    int n_done    = 0;
    int start_cyc = -1000;
    int done_cyc  = -1000;

    logic [19:0]     exp_launch [$];
    logic [ID_W+1:0] exp_done   [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        logic [19:0]     exl;
        logic [ID_W+1:0] exd;
        @(posedge clk);
        #1;
        cyc++;
        if (sif.eng_start === 1'b1) begin
            n_start++;
            start_cyc = cyc;
            if (exp_launch.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_start: observed=1 expected=0 at cycle %0d", cyc);
            end else begin
                exl = exp_launch.pop_front();
                chk("launch_desc", {sif.eng_h0, sif.eng_v0, sif.eng_sw, sif.eng_sh}, exl);
            end
        end
        if (sif.done_valid === 1'b1) begin
            n_done++;
            done_cyc = cyc;
            if (exp_done.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_done: observed id=%0h err=%0h expected none",
                       sif.done_id, sif.done_err);
            end else begin
                exd = exp_done.pop_front();
                chk("done_id_err", {sif.done_id, sif.done_err}, exd);
            end
        end
    endtask

    task automatic push_job(input logic [5:0] h0, input logic [5:0] v0, input logic [3:0] sw,
                            input logic [3:0] sh, input logic [ID_W-1:0] id, input logic accept);
        logic ok;
        sif.job_h0    = h0;
        sif.job_v0    = v0;
        sif.job_sw    = sw;
        sif.job_sh    = sh;
        sif.job_id    = id;
        sif.job_valid = 1'b1;
        chk("job_ready", sif.job_ready, accept);
        if (accept) begin
            ok = (sw != 4'd0) && (sh != 4'd0) &&
                 (int'(h0) + int'(sw) <= 63) && (int'(v0) + int'(sh) <= 63);
            exp_done.push_back({id, (ok ? 2'b00 : 2'b01)});
            if (ok) exp_launch.push_back({h0, v0, sw, sh});
        end
        tick();
        sif.job_valid = 1'b0;
    endtask

    task automatic beats(input int n);
        sif.eng_o_valid = 1'b1;
        repeat (n) tick();
        sif.eng_o_valid = 1'b0;
    endtask

    task automatic wait_start(input int budget, input string tag);
        int n0;
        int k;
        n0 = n_start;
        k  = 0;
        while (n_start == n0 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, n_start - n0, 1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n0;
        int k;
        n0 = n_done;
        k  = 0;
        while (n_done == n0 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, n_done - n0, 1);
    endtask

    task automatic run_one(input string tag);
        wait_start(20, {tag, "_start"});
        beats(OUT_PER_JOB);
        wait_done(20, {tag, "_done"});
    endtask

    initial begin
        int push_cyc;
        int last_beat;
        int n0;

        sif.job_valid   = 1'b0;
        sif.job_h0      = '0;
        sif.job_v0      = '0;
        sif.job_sw      = '0;
        sif.job_sh      = '0;
        sif.job_id      = '0;
        sif.eng_o_valid = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_job_ready", sif.job_ready, 1);
        chk("rst_eng_start", sif.eng_start, 0);
        chk("rst_eng_desc", {sif.eng_h0, sif.eng_v0, sif.eng_sw, sif.eng_sh}, 0);
        chk("rst_busy", sif.busy, 0);
        chk("rst_pending", sif.pending, 0);
        chk("rst_done_valid", sif.done_valid, 0);
        chk("rst_done_id_err", {sif.done_id, sif.done_err}, 0);
        RST = 1'b0;
        tick();
        tick();

        // single job: latency to START and from last beat to done
        push_job(6'd10, 6'd20, 4'd4, 4'd4, 4'd3, 1'b1);
        push_cyc = cyc;
        tick();
        tick();
        chk("start_latency", start_cyc - push_cyc, 2);
        chk("busy_in_run", sif.busy, 1);
        beats(OUT_PER_JOB);
        last_beat = cyc;
        chk("eng_h0_stable", sif.eng_h0, 10);
        wait_done(20, "single_done");
        chk("done_latency", done_cyc - last_beat, 3);
        tick();
        chk("busy_after_done", sif.busy, 0);

        // geometry rejects and a window touching the image edge
        push_job(6'd60, 6'd0, 4'd4, 4'd1, 4'd5, 1'b1);
        wait_done(10, "rej_h_done");
        push_job(6'd0, 6'd0, 4'd1, 4'd0, 4'd6, 1'b1);
        wait_done(10, "rej_sh0_done");
        push_job(6'd0, 6'd60, 4'd1, 4'd4, 4'd7, 1'b1);
        wait_done(10, "rej_v_done");
        push_job(6'd59, 6'd62, 4'd4, 4'd1, 4'd8, 1'b1);
        run_one("edge_ok");

        // FIFO full while the engine is busy
        push_job(6'd1, 6'd2, 4'd3, 4'd4, 4'd9, 1'b1);
        wait_start(20, "full_a_start");
        push_job(6'd5, 6'd5, 4'd1, 4'd1, 4'd10, 1'b1);
        push_job(6'd6, 6'd7, 4'd2, 4'd2, 4'd11, 1'b1);
        push_job(6'd0, 6'd0, 4'd15, 4'd15, 4'd12, 1'b1);
        push_job(6'd48, 6'd48, 4'd15, 4'd15, 4'd13, 1'b1);
        push_job(6'd1, 6'd1, 4'd1, 4'd1, 4'd14, 1'b0);
        chk("pending_full", sif.pending, 4);
        chk("ready_full", sif.job_ready, 0);
        beats(OUT_PER_JOB);
        wait_done(20, "full_a_done");
        repeat (4) run_one("full_q");
        repeat (10) tick();
        chk("full_drained_pending", sif.pending, 0);
        chk("full_drained_busy", sif.busy, 0);

        // stray beats while idle, then too many beats in RUN
        beats(10);
        push_job(6'd20, 6'd30, 4'd5, 4'd6, 4'd1, 1'b1);
        wait_start(20, "extra_start");
        n0 = n_done;
        beats(300);
        repeat (10) tick();
        chk("extra_one_done", n_done - n0, 1);
        chk("extra_busy", sif.busy, 0);
        push_job(6'd2, 6'd3, 4'd4, 4'd5, 4'd2, 1'b1);
        run_one("after_extra");

        // reset in the middle of RUN with one job still queued
        push_job(6'd7, 6'd7, 4'd7, 4'd7, 4'd4, 1'b1);
        wait_start(20, "rstmid_start");
        beats(100);
        push_job(6'd1, 6'd1, 4'd1, 4'd1, 4'd5, 1'b1);
        chk("rstmid_pending_before", sif.pending, 1);
        exp_done.delete();
        exp_launch.delete();
        n0 = n_done;
        RST = 1'b1;
        #1;
        chk("rstmid_pending", sif.pending, 0);
        chk("rstmid_job_ready", sif.job_ready, 1);
        chk("rstmid_busy", sif.busy, 0);
        chk("rstmid_eng_desc", {sif.eng_h0, sif.eng_v0, sif.eng_sw, sif.eng_sh}, 0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        chk("rstmid_no_start", sif.eng_start, 0);
        chk("rstmid_no_done", n_done - n0, 0);
        repeat (5) tick();
        chk("rstmid_idle_busy", sif.busy, 0);
        push_job(6'd3, 6'd3, 4'd3, 4'd3, 4'd6, 1'b1);
        run_one("after_rst");

        // engine that never answers
        push_job(6'd4, 6'd4, 4'd2, 4'd2, 4'd15, 1'b1);
`ifdef INTERP_JOB_TIMEOUT_EN
        void'(exp_done.pop_back());
        exp_done.push_back({4'd15, 2'b10});
        wait_start(20, "timeout_start");
        wait_done(TIMEOUT_CYC + 100, "timeout_done");
        chk("timeout_latency", done_cyc - start_cyc, TIMEOUT_CYC + 1);
`else
        wait_start(20, "hang_start");
        n0 = n_done;
        repeat (TIMEOUT_CYC + 100) tick();
        chk("hang_busy", sif.busy, 1);
        chk("hang_no_done", n_done - n0, 0);
        exp_done.delete();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        chk("hang_cleared", sif.busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL sim_timeout: simulation exceeded its time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule
